pipe_wb_stage: RTL
==================

Name: pipe_wb_stage

Overview:
- Parametrised successor to the fixed MEM/WB pipeline latch.
- Chain of NUM_STAGES handshaked pipeline registers carrying instruction word, PC+8, ALU result, read data and a write-enable bit.
- Adds valid/ready backpressure, synchronous flush and kill of write-enable for NOP (all-zero) instructions.
- Sits between memory stage and register-file writeback; NUM_STAGES>1 absorbs multi-cycle memory latency.

Parameters:
- DATA_W, 32, width of IR, PC8, AO and DR fields.
- NUM_STAGES, 1, register stages in the chain, legal 1..4.
- NOP_WORD, 0, IR value treated as bubble; its write-enable is forced to 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage chain accepts beat this cycle.
- ir_in, pc8_in, ao_in, dr_in  in  DATA_W each  upstream payload.
- we_in  in  1  upstream register-write enable.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  output stage holds a beat.
- out_ready  in  1  writeback consumes beat.
- ir_out, pc8_out, ao_out, dr_out  out  DATA_W each  output-stage payload.
- we_out  out  1  qualified write enable: stored we AND out_valid.
- stall_cnt  out  16  stall counter (see Optional Feature).
- nop_cnt  out  16  killed-NOP counter (see Optional Feature).

Behaviour:
- Per stage k (0..NUM_STAGES-1): valid_k, ir_k, pc8_k, ao_k, dr_k, we_k. Stage NUM_STAGES-1 drives outputs.
- reset low: all valid_k, payload and we_k cleared to 0 immediately. Outputs: out_valid=0, we_out=0, all data outs 0, counters 0. in_ready follows its equation and is combinationally 1 while flush=0.
- Advance enable: adv_last = out_ready OR NOT valid_last; adv_k = adv_{k+1} OR NOT valid_k. in_ready = adv_0 AND NOT flush.
- On a clock edge with adv_k=1, stage k loads from stage k-1 (stage 0 loads from inputs). valid_0 <= in_valid AND in_ready.
- A stage whose source is invalid loads valid=0 and a zero payload.
- When adv_k=0, stage k holds all fields unchanged.
- NOP kill at stage 0 entry: we_0 <= we_in AND (ir_in != NOP_WORD). An accepted NOP still occupies a slot with valid=1, we=0.
- Latency with out_ready held 1: beat accepted at edge N appears on outputs after edge N+NUM_STAGES-1, i.e. visible NUM_STAGES-1 cycles after the accept edge. NUM_STAGES=1 matches the legacy single-latch timing.
- Throughput: one beat per cycle when out_ready=1. With out_ready=0 the chain fills fully, then in_ready=0.
- Simultaneous consume at output and accept at input when full: allowed in the same cycle; no bubble is inserted.
- flush=1: at the next edge all valid_k<=0, we_k<=0 and payloads<=0. in_ready=0 for that cycle, so no input is accepted. flush overrides out_ready/in_valid. A beat on the outputs during the flush cycle is still consumed by a downstream that sees out_valid=1 AND out_ready=1.
- Reset asserted mid-stream: all in-flight beats are discarded and none are replayed.
- Payload fields pass through unchanged. No arithmetic is performed on payloads.

Optional Feature:
- Macro PIPE_WB_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 AND out_ready=0.
  - nop_cnt increments on each accepted beat with ir_in==NOP_WORD.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on reset only (not on flush).
- Undefined: counter logic is absent and both ports are tied to 16'h0000.

Test Plan:
- NUM_STAGES=1, stream ir 32'h8C010004 with we_in=1, out_ready=1 → outputs show ir_out=32'h8C010004, we_out=1 one edge later; one beat per cycle sustained.
- NUM_STAGES=3, send ir_in=0 with we_in=1 → beat emerges after 3 edges with out_valid=1, we_out=0; with stats enabled, nop_cnt=1.
- NUM_STAGES=3, out_ready=0 for 6 cycles while in_valid=1 → in_ready drops after 3 accepts; release → beats exit in order, none lost or duplicated; stall_cnt counts cycles with out_valid=1 and out_ready=0.
- Full chain with flush pulsed 1 cycle → next cycle out_valid=0, we_out=0, ir_out=0; in_ready=0 during the flush cycle; first post-flush input appears after NUM_STAGES edges.
- reset pulsed low asynchronously mid-cycle with 2 beats in flight → outputs zero immediately without a clock edge; counters read 0.
- Build without PIPE_WB_STATS_EN and apply stall traffic → stall_cnt and nop_cnt remain 16'h0000.

Source files
------------

// File: rtl/pipe_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_wb_stage
// Description : MEM/WB pipeline latch generalised to a chain of NUM_STAGES
//               valid/ready handshaked registers. Each stage carries IR, PC+8,
//               ALU result, read data and a write-enable bit. Supports
//               synchronous flush, asynchronous active-low reset and forces
//               write-enable low for NOP instruction words.
//               Optional statistics counters are enabled by defining the
//               macro PIPE_WB_STATS_EN; when it is undefined both counter
//               ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_stage #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_STAGES = 1,
    parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ir_in,
    input  logic [DATA_W-1:0] pc8_in,
    input  logic [DATA_W-1:0] ao_in,
    input  logic [DATA_W-1:0] dr_in,
    input  logic              we_in,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] pc8_out,
    output logic [DATA_W-1:0] ao_out,
    output logic [DATA_W-1:0] dr_out,
    output logic              we_out,

    output logic [15:0]       stall_cnt,
    output logic [15:0]       nop_cnt
);

    // A beat is stored as one packed word: {we, ir, pc8, ao, dr}.
    localparam int BEAT_W = 4 * DATA_W + 1;
    localparam int LAST   = NUM_STAGES - 1;
    localparam int DR_LSB  = 0;
    localparam int AO_LSB  = DATA_W;
    localparam int PC8_LSB = 2 * DATA_W;
    localparam int IR_LSB  = 3 * DATA_W;
    localparam int WE_BIT  = 4 * DATA_W;

    logic [NUM_STAGES-1:0] valid_q;
    logic [BEAT_W-1:0]     beat_q    [NUM_STAGES];
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] src_valid;
    logic [BEAT_W-1:0]     src_beat  [NUM_STAGES];
    logic                  accept;
    logic                  in_is_nop;
    logic [BEAT_W-1:0]     in_beat;

    // A stage may advance when it or any stage downstream of it is empty, or
    // when the writeback side consumes. Written as a reduction over the
    // downstream valid bits so no signal depends on itself.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&valid_q[LAST:k]);
    end

    assign in_ready  = adv[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign in_is_nop = (ir_in == NOP_WORD);

    // NOP bubbles still occupy a slot but never write the register file.
    assign in_beat = {we_in & ~in_is_nop, ir_in, pc8_in, ao_in, dr_in};

    // Source selection for each stage: inputs for stage 0, previous stage
    // otherwise. An invalid source always presents a zero payload.
    always_comb begin
        src_valid    = '0;
        src_beat     = '{default: '0};
        src_valid[0] = accept;
        src_beat[0]  = accept ? in_beat : '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_beat[k]  = valid_q[k-1] ? beat_q[k-1] : '0;
        end
    end

    // Stage registers: clear on reset or flush, load on advance, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                beat_q[k] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                beat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= src_valid[k];
                    beat_q[k]  <= src_beat[k];
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign ir_out    = beat_q[LAST][IR_LSB  +: DATA_W];
    assign pc8_out   = beat_q[LAST][PC8_LSB +: DATA_W];
    assign ao_out    = beat_q[LAST][AO_LSB  +: DATA_W];
    assign dr_out    = beat_q[LAST][DR_LSB  +: DATA_W];
    // Qualified so an empty output stage can never request a write.
    assign we_out    = beat_q[LAST][WE_BIT] & valid_q[LAST];

`ifdef PIPE_WB_STATS_EN
    logic        stall_evt;
    logic        nop_evt;
    logic [15:0] stall_q;
    logic [15:0] nop_q;

    assign stall_evt = out_valid & ~out_ready;
    assign nop_evt   = accept & in_is_nop;

    // Saturating event counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            nop_q   <= '0;
        end else begin
            if (stall_evt && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (nop_evt && (nop_q != 16'hFFFF)) begin
                nop_q <= nop_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign nop_cnt   = nop_q;
`else
    assign stall_cnt = 16'h0000;
    assign nop_cnt   = 16'h0000;
`endif

endmodule
`default_nettype wire
